guess_search: RTL and testbench
===============================

// Module: guess_search
// PURPOSE
//   Sequential binary-search initiator that sits on the driving side of a
//   magnitude comparator: it issues guesses and consumes LT/EQ/GrT verdicts.
//   Convention: the comparator compares x1 = guess against x2 = hidden target.
//   On start it finds the target in at most W+1 probes, then reports it.
//   It is used to recover an unknown value through a compare-only interface.
// PARAMETERS
//   W        4    width of guess/target in bits (W >= 1)
//   CNT_W    4    width of probe counter; must satisfy 2^CNT_W > W+1
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous reset, active-high
//   start        in   1      begin a search; sampled only in IDLE
//   rsp_valid    in   1      LT/EQ/GrT are valid for the current guess
//   LT           in   1      guess < target
//   EQ           in   1      guess == target
//   GrT          in   1      guess > target
//   guess        out  W      current probe value (the comparator's x1)
//   guess_valid  out  1      high while in ASK; guess is stable
//   busy         out  1      high in ASK
//   done         out  1      one-cycle pulse when the search ends
//   found        out  1      held: last search hit EQ
//   err          out  1      held: last search aborted on non-one-hot flags
//   result       out  W      held: matched value (0 if not found)
//   probes       out  CNT_W  held: number of responses consumed by the last search
// BEHAVIOUR
//   Reset (async): state=IDLE. guess=0, guess_valid=0, busy=0, done=0,
//     found=0, err=0, result=0, probes=0. Internal lo=0, hi=2^W-1.
//   lo and hi are W+1 bits wide so that lo > hi can be detected with no wrap.
//   guess = (lo+hi)>>1, registered and truncated to W bits.
//   FSM states: IDLE, ASK, FIN.
//   IDLE: on start=1, load lo=0, hi=2^W-1, guess=(2^W-1)>>1, probes=0.
//     Clear found, err and result, then go to ASK. rsp_valid is ignored here.
//   ASK: guess_valid=1 and busy=1. Each edge with rsp_valid=1:
//     - flags not exactly one-hot: err=1, found=0, go to FIN.
//     - EQ: found=1, result=guess, go to FIN.
//     - LT: lo=guess+1. GrT: hi=guess-1 (W+1-bit arithmetic; guess=0
//       gives hi=-1, which is detected as empty via the sign/lo>hi check).
//     - If the new lo > hi: found=0, go to FIN. Otherwise load the new guess
//       on the same edge and stay in ASK.
//     - probes increments on every response consumed, including the last one.
//   With rsp_valid=0 in ASK, all state holds.
//   A responder may answer every cycle, giving one probe per clock.
//   FIN: done=1 for exactly one cycle, then IDLE. Results are held until
//     the next start.
//   start while in ASK or FIN is ignored; there is no restart mid-search.
//   Latency: start edge -> first guess_valid in the next cycle. The final
//     response edge -> done in the next cycle.
//   Reset during ASK aborts immediately to the reset values; no done pulse.
// TESTING (W=4, responder models a comparator against a fixed target)
//   1 target=11, 1-cycle responder -> guesses 7,11; found=1, result=11,
//     probes=2, done pulses once.
//   2 target=0 -> guesses 7,3,1,0; found=1, probes=4.
//     target=15 -> 7,11,13,14,15; probes=5.
//   3 responder always GrT -> guesses 7,3,1,0, then empty range; found=0,
//     err=0, result=0, probes=4.
//   4 first response LT=1 and GrT=1 together -> err=1, found=0, probes=1,
//     done pulses.
//     Separately, rsp_valid low for 3 cycles mid-search -> guess holds and
//     probes is unchanged.
//   5 assert rst after the 2nd guess of a target=5 search -> all outputs go
//     to 0 asynchronously with no done. A fresh start then finds 5 with
//     probes=3 (7,3,5).
//   6 start pulsed while busy and rsp_valid pulsed in IDLE -> no effect.
//     Sweep all 16 targets -> all found, probes <= 5.

Source files
------------

// File: rtl/guess_search.sv
// Binary-search initiator driving a magnitude comparator (x1 = guess, x2 = hidden target).
// Issues guesses and consumes LT/EQ/GrT verdicts until a hit, an empty range, or malformed flags.
module guess_search #(
    parameter int W     = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rsp_valid,
    input  logic             LT,
    input  logic             EQ,
    input  logic             GrT,
    output logic [W-1:0]     guess,
    output logic             guess_valid,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [W-1:0]     result,
    output logic [CNT_W-1:0] probes
);

    typedef enum logic [1:0] {IDLE, ASK, FIN} state_t;

    localparam logic [W:0]   HI_INIT    = {1'b0, {W{1'b1}}};
    localparam logic [W-1:0] GUESS_INIT = W'(HI_INIT >> 1);

    state_t           state_reg,  state_next;
    logic [W:0]       lo_reg,     lo_next;
    logic [W:0]       hi_reg,     hi_next;
    logic [W-1:0]     guess_reg,  guess_next;
    logic [W-1:0]     result_reg, result_next;
    logic [CNT_W-1:0] probes_reg, probes_next;
    logic             found_reg,  found_next;
    logic             err_reg,    err_next;

    // Bounds are one bit wider than the guess so hi = -1 and lo = 2^W stay distinguishable.
    logic [W:0]       lo_step;
    logic [W:0]       hi_step;
    logic [W:0]       mid_sum;
    logic             one_hot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            lo_reg     <= '0;
            hi_reg     <= HI_INIT;
            guess_reg  <= '0;
            result_reg <= '0;
            probes_reg <= '0;
            found_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            lo_reg     <= lo_next;
            hi_reg     <= hi_next;
            guess_reg  <= guess_next;
            result_reg <= result_next;
            probes_reg <= probes_next;
            found_reg  <= found_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        lo_next     = lo_reg;
        hi_next     = hi_reg;
        guess_next  = guess_reg;
        result_next = result_reg;
        probes_next = probes_reg;
        found_next  = found_reg;
        err_next    = err_reg;
        lo_step     = lo_reg;
        hi_step     = hi_reg;
        mid_sum     = '0;
        one_hot     = ({LT, EQ, GrT} == 3'b100) || ({LT, EQ, GrT} == 3'b010) ||
                      ({LT, EQ, GrT} == 3'b001);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    lo_next     = '0;
                    hi_next     = HI_INIT;
                    guess_next  = GUESS_INIT;
                    probes_next = '0;
                    found_next  = 1'b0;
                    err_next    = 1'b0;
                    result_next = '0;
                    state_next  = ASK;
                end
            end
            ASK: begin
                if (rsp_valid) begin
                    probes_next = probes_reg + CNT_W'(1);
                    if (!one_hot) begin
                        err_next   = 1'b1;
                        found_next = 1'b0;
                        state_next = FIN;
                    end else if (EQ) begin
                        found_next  = 1'b1;
                        result_next = guess_reg;
                        state_next  = FIN;
                    end else begin
                        if (LT) begin
                            lo_step = {1'b0, guess_reg} + (W+1)'(1);
                        end else begin
                            hi_step = {1'b0, guess_reg} - (W+1)'(1);
                        end
                        lo_next = lo_step;
                        hi_next = hi_step;
                        // A set top bit on hi means it went negative: the range is empty.
                        if (hi_step[W] || (lo_step > hi_step)) begin
                            found_next = 1'b0;
                            state_next = FIN;
                        end else begin
                            mid_sum    = lo_step + hi_step;
                            guess_next = W'(mid_sum >> 1);
                        end
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign guess       = guess_reg;
    assign guess_valid = (state_reg == ASK);
    assign busy        = (state_reg == ASK);
    assign done        = (state_reg == FIN);
    assign found       = found_reg;
    assign err         = err_reg;
    assign result      = result_reg;
    assign probes      = probes_reg;

endmodule

// File: tb/tb_guess_search.sv
// Randomized scoreboard bench for guess_search: a comparator responder answers probes,
// a behavioural search model predicts each outcome and a monitor checks it at done.
module tb_guess_search;

    localparam int W     = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             rsp_valid;
    logic             LT;
    logic             EQ;
    logic             GrT;
    logic [W-1:0]     guess;
    logic             guess_valid;
    logic             busy;
    logic             done;
    logic             found;
    logic             err;
    logic [W-1:0]     result;
    logic [CNT_W-1:0] probes;

    guess_search #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .rsp_valid(rsp_valid),
        .LT(LT), .EQ(EQ), .GrT(GrT), .guess(guess), .guess_valid(guess_valid),
        .busy(busy), .done(done), .found(found), .err(err), .result(result),
        .probes(probes)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int g[8];
        bit found;
        bit err;
        int result;
        int probes;
    } exp_t;

    exp_t exp_q[$];
    int   obs_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Responder configuration: mode 0 = comparator against target, 1 = always GrT,
    // 2 = LT and GrT together (malformed).
    int mode        = 0;
    int target      = 0;
    int resp_limit  = 0;
    int resp_count  = 0;
    bit rand_gaps   = 0;
    bit stall_req   = 0;
    bit idle_poke   = 0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Plain interval-halving reference over integers.
    function automatic exp_t model(input int t, input int m);
        exp_t e;
        int lo, hi, g;
        e.n = 0; e.found = 0; e.err = 0; e.result = 0; e.probes = 0;
        for (int i = 0; i < 8; i++) e.g[i] = 0;
        lo = 0;
        hi = (1 << W) - 1;
        for (int i = 0; i < 8; i++) begin
            g = (lo + hi) / 2;
            e.g[e.n] = g;
            e.n++;
            e.probes++;
            if (m == 2) begin
                e.err = 1;
                break;
            end
            if (m == 0 && g == t) begin
                e.found  = 1;
                e.result = g;
                break;
            end
            if (m == 0 && g < t) lo = g + 1;
            else                 hi = g - 1;
            if (lo > hi) break;
        end
        return e;
    endfunction

    // Responder
    initial begin
        int hold_g, hold_p;
        rsp_valid = 0; LT = 0; EQ = 0; GrT = 0;
        forever begin
            @(negedge clk);
            rsp_valid = 0; LT = 0; EQ = 0; GrT = 0;
            if (!rst && guess_valid) begin
                if (stall_req && resp_count == 2) begin
                    hold_g = guess;
                    hold_p = probes;
                    repeat (3) begin
                        check("stall_guess_hold", guess, hold_g);
                        check("stall_probes_hold", probes, hold_p);
                        @(negedge clk);
                    end
                    stall_req = 0;
                end
                if (resp_count < resp_limit && !(rand_gaps && $urandom_range(0, 3) == 0)) begin
                    rsp_valid = 1;
                    obs_q.push_back(int'(guess));
                    resp_count++;
                    case (mode)
                        0: begin
                            LT  = (int'(guess) < target);
                            EQ  = (int'(guess) == target);
                            GrT = (int'(guess) > target);
                        end
                        1: GrT = 1;
                        default: begin
                            LT  = 1;
                            GrT = 1;
                        end
                    endcase
                end
            end else if (!rst && idle_poke) begin
                rsp_valid = 1;
                EQ        = 1;
                idle_poke = 0;
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        int   n;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1, expected no pending search");
                end else begin
                    e = exp_q.pop_front();
                    check("found", found, e.found);
                    check("err", err, e.err);
                    check("result", result, e.result);
                    check("probes", probes, e.probes);
                    check("guess_count", obs_q.size(), e.n);
                    n = (obs_q.size() < e.n) ? obs_q.size() : e.n;
                    for (int i = 0; i < n; i++) check("guess_seq", obs_q[i], e.g[i]);
                    obs_q.delete();
                end
            end
        end
    end

    task automatic run_search(input int t, input int m, input bit gaps, input bit poke_busy);
        exp_t e;
        int   k;
        e = model(t, m);
        exp_q.push_back(e);
        target     = t;
        mode       = m;
        rand_gaps  = gaps;
        resp_count = 0;
        resp_limit = 100;
        start = 1;
        @(negedge clk);
        start = 0;
        if (poke_busy) begin
            @(negedge clk);
            start = 1;
            @(negedge clk);
            start = 0;
        end
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL search_timeout: got no done after %0d cycles, expected done", k);
            exp_q.delete();
        end
        @(negedge clk);
        check("held_found", found, e.found);
        check("held_result", result, e.result);
        check("held_probes", probes, e.probes);
        check("idle_busy", busy, 0);
        $display("search target=%0d mode=%0d found=%0d err=%0d result=%0d probes=%0d",
                 t, m, found, err, result, probes);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst = 1;
        start = 0;
        #12;
        check("rst_guess", guess, 0);
        check("rst_guess_valid", guess_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        check("rst_probes", probes, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        run_search(11, 0, 0, 0);
        run_search(0, 0, 0, 0);
        run_search(15, 0, 0, 1);
        run_search(9, 1, 0, 0);
        run_search(6, 2, 0, 0);

        stall_req = 1;
        run_search(13, 0, 0, 0);
        check("stall_consumed", stall_req, 0);

        idle_poke = 1;
        repeat (3) @(negedge clk);
        check("idle_poke_busy", busy, 0);
        check("idle_poke_found", found, 1);
        check("idle_poke_result", result, 13);
        check("idle_poke_probes", probes, 3);
        $display("idle rsp_valid pulse: busy=%0d probes=%0d", busy, probes);

        // Reset mid-search: answer only the first probe, then reset while guess 3 is shown.
        target = 5; mode = 0; rand_gaps = 0; resp_count = 0; resp_limit = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        k = 0;
        while (!(guess_valid && guess == 3) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("abort_guess_before", guess, 3);
        #2 rst = 1;
        #1;
        check("abort_guess", guess, 0);
        check("abort_guess_valid", guess_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_found", found, 0);
        check("abort_err", err, 0);
        check("abort_result", result, 0);
        check("abort_probes", probes, 0);
        @(negedge clk);
        obs_q.delete();
        rst = 0;
        @(negedge clk);
        $display("reset abort during ASK: outputs cleared");
        run_search(5, 0, 0, 0);

        for (int t = 0; t < 16; t++) begin
            run_search(t, 0, 1, 0);
            check("sweep_probes_le5", int'(probes <= 5), 1);
        end

        for (int i = 0; i < 20; i++) begin
            int m;
            m = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_search(int'($urandom_range(0, 15)), m, bit'($urandom_range(0, 1)),
                       bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
